// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   muldiv_op_t    : operation select carried on op_ex
//   muldiv_state_t : sequencer states of muldiv_unit
//   MULDIV_CYCLES  : iterations per operation (one result bit per cycle)
package mips_pkg;

    localparam int unsigned MULDIV_CYCLES = 32;

    typedef enum logic [1:0] {
        OpMult  = 2'd0,
        OpMultu = 2'd1,
        OpDiv   = 2'd2,
        OpDivu  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the shared multiply / divide datapath.
// The operation works on unsigned magnitudes held in a 64-bit {acc_hi, acc_lo} pair.
//   is_div_i  : 1 = restoring-division step, 0 = shift-add multiply step
//   acc_hi_i  : multiply partial product high half / divide partial remainder
//   acc_lo_i  : multiply multiplier + product low half / divide dividend + quotient
//   opb_i     : multiplicand / divisor magnitude
//   acc_hi_o, acc_lo_o : accumulator after this step
module muldiv_iter (
    input  logic        is_div_i,
    input  logic [31:0] acc_hi_i,
    input  logic [31:0] acc_lo_i,
    input  logic [31:0] opb_i,
    output logic [31:0] acc_hi_o,
    output logic [31:0] acc_lo_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] sub;
    logic        ge;

    always_comb begin
        // Multiply: conditionally add, then shift the 65-bit {carry, hi, lo} right.
        sum = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opb_i} : 33'd0);

        // Divide: shift the next dividend bit into the remainder and try a subtract.
        // The remainder stays below the divisor, so a successful difference fits 32 bits.
        shifted = {acc_hi_i, acc_lo_i[31]};
        ge      = (shifted >= {1'b0, opb_i});
        sub     = shifted[31:0] - opb_i;

        if (is_div_i) begin
            acc_hi_o = ge ? sub : shifted[31:0];
            acc_lo_o = {acc_lo_i[30:0], ge};
        end else begin
            acc_hi_o = sum[32:1];
            acc_lo_o = {sum[0], acc_lo_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
//   clk, rst_n         : clock, synchronous active-low reset
//   start_ex, op_ex    : issue request and operation (MULT/MULTU/DIV/DIVU)
//   opa_ex, opb_ex     : rs / rt operands
//   mthi_ex, mtlo_ex   : direct HI / LO writes with mt_data_ex
//   hilo_read_id       : ID stage holds MFHI/MFLO
//   flush              : abort any in-flight operation
//   hi, lo             : architectural HI / LO
//   busy, done         : in RUN / one-cycle DONE pulse
//   stall_id           : hazard request to ID
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = mips_pkg::MULDIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_ex,
    input  muldiv_op_t  op_ex,
    input  logic [31:0] opa_ex,
    input  logic [31:0] opb_ex,
    input  logic        mthi_ex,
    input  logic        mtlo_ex,
    input  logic [31:0] mt_data_ex,
    input  logic        hilo_read_id,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_id
);

    localparam int unsigned CntW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MULDIV_CYCLES - 1);

    muldiv_state_t   state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     acc_hi_q, acc_lo_q, opb_q;
    logic            is_div_q, neg_q, neg_rem_q, div0_q;
    logic [31:0]     hi_q, lo_q;

    // Operand preparation at issue
    logic        is_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    // Iteration step and final sign fix-up
    logic [31:0] it_hi, it_lo;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        is_signed = (op_ex == OpMult) || (op_ex == OpDiv);
        sign_a    = is_signed & opa_ex[31];
        sign_b    = is_signed & opb_ex[31];
        mag_a     = sign_a ? (~opa_ex + 32'd1) : opa_ex;
        mag_b     = sign_b ? (~opb_ex + 32'd1) : opb_ex;
    end

    muldiv_iter u_iter (
        .is_div_i (is_div_q),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opb_i    (opb_q),
        .acc_hi_o (it_hi),
        .acc_lo_o (it_lo)
    );

    always_comb begin
        prod   = {it_hi, it_lo};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div_q) begin
            // Remainder takes the dividend's sign; this also returns raw opa on divide by zero.
            res_hi = neg_rem_q ? (~it_hi + 32'd1) : it_hi;
            if (div0_q) begin
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = neg_q ? (~it_lo + 32'd1) : it_lo;
            end
        end else if (neg_q) begin
            prod   = ~prod + 64'd1;
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!flush) begin
                        if (mthi_ex) hi_q <= mt_data_ex;
                        if (mtlo_ex) lo_q <= mt_data_ex;
                        if (start_ex) begin
                            acc_hi_q  <= '0;
                            acc_lo_q  <= mag_a;
                            opb_q     <= mag_b;
                            is_div_q  <= op_ex[1];
                            neg_q     <= sign_a ^ sign_b;
                            neg_rem_q <= sign_a;
                            div0_q    <= (opb_ex == 32'd0);
                            cnt_q     <= '0;
                            state_q   <= StRun;
                        end
                    end
                end
                StRun: begin
                    // HI/LO moves and new issues are dropped while running.
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_hi_q <= it_hi;
                        acc_lo_q <= it_lo;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            hi_q    <= res_hi;
                            lo_q    <= res_lo;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (!flush) begin
                        if (mthi_ex) hi_q <= mt_data_ex;
                        if (mtlo_ex) lo_q <= mt_data_ex;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign stall_id = (hilo_read_id && ((state_q == StRun) || ((state_q == StIdle) && start_ex)))
                   || (start_ex && (state_q == StRun));

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_ex = 1'b0;
    muldiv_op_t  op_ex = OpMult;
    logic [31:0] opa_ex = '0, opb_ex = '0;
    logic        mthi_ex = 1'b0, mtlo_ex = 1'b0;
    logic [31:0] mt_data_ex = '0;
    logic        hilo_read_id = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, stall_id;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.MULDIV_CYCLES(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_ex     (start_ex),
        .op_ex        (op_ex),
        .opa_ex       (opa_ex),
        .opb_ex       (opb_ex),
        .mthi_ex      (mthi_ex),
        .mtlo_ex      (mtlo_ex),
        .mt_data_ex   (mt_data_ex),
        .hilo_read_id (hilo_read_id),
        .flush        (flush),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done),
        .stall_id     (stall_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to the DONE pulse, checking latency and result.
    task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit read);
        int busy_cnt, stall_cnt, cyc;
        start_ex     = 1'b1;
        op_ex        = op;
        opa_ex       = a;
        opb_ex       = b;
        hilo_read_id = read;
        #1;
        if (read) chk({tag, ".stall_issue"}, {31'd0, stall_id}, 32'd1);
        tick();
        start_ex  = 1'b0;
        busy_cnt  = 0;
        stall_cnt = 0;
        cyc       = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (stall_id === 1'b1) stall_cnt++;
            tick();
            cyc++;
        end
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_cycles"}, busy_cnt, 32'd32);
        chk({tag, ".hi"}, hi, ehi);
        chk({tag, ".lo"}, lo, elo);
        if (read) begin
            chk({tag, ".stall_run"}, stall_cnt, 32'd32);
            chk({tag, ".stall_done"}, {31'd0, stall_id}, 32'd0);
        end
        tick();
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        hilo_read_id = 1'b0;
    endtask

    initial begin
        int cyc;

        // Reset
        tick();
        tick();
        chk("rst.hi", hi, 32'h0);
        chk("rst.lo", lo, 32'h0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        start_ex = 1'b1;
        #1;
        chk("rst.stall_noread", {31'd0, stall_id}, 32'd0);
        start_ex = 1'b0;
        rst_n = 1'b1;
        tick();

        // Main vectors
        run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               1'b0);
        run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", OpDivu, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
               1'b0);
        run_op("div_zero_s", OpDiv, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);

        // start_ex in DONE is ignored
        start_ex = 1'b1;
        op_ex    = OpMultu;
        opa_ex   = 32'd5;
        opb_ex   = 32'd5;
        tick();
        start_ex = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("done_start.done", {31'd0, done}, 32'd1);
        start_ex = 1'b1;
        tick();
        start_ex = 1'b0;
        chk("done_start.busy", {31'd0, busy}, 32'd0);
        chk("done_start.lo", lo, 32'd25);

        // HI/LO moves together with issue land at E0, then the result overwrites them
        mthi_ex    = 1'b1;
        mtlo_ex    = 1'b1;
        mt_data_ex = 32'hCAFE_F00D;
        start_ex   = 1'b1;
        op_ex      = OpMultu;
        opa_ex     = 32'd2;
        opb_ex     = 32'd3;
        tick();
        mthi_ex  = 1'b0;
        mtlo_ex  = 1'b0;
        start_ex = 1'b0;
        chk("mt_e0.hi", hi, 32'hCAFE_F00D);
        chk("mt_e0.lo", lo, 32'hCAFE_F00D);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("mt_e32.hi", hi, 32'h0);
        chk("mt_e32.lo", lo, 32'd6);
        tick();

        // Flush at the 10th RUN cycle, with a dropped MTHI during RUN
        start_ex = 1'b1;
        op_ex    = OpMultu;
        opa_ex   = 32'd1000;
        opb_ex   = 32'd1000;
        tick();
        start_ex = 1'b0;
        for (int i = 1; i < 10; i++) begin
            mthi_ex    = (i == 4);
            mt_data_ex = 32'hDEAD_BEEF;
            tick();
        end
        mthi_ex = 1'b0;
        chk("flush.busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", {31'd0, busy}, 32'd0);
        chk("flush.hi", hi, 32'h0);
        chk("flush.lo", lo, 32'd6);
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) cyc++;
            tick();
        end
        chk("flush.no_done", cyc, 32'd0);
        run_op("after_flush", OpMultu, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);

        // Reset mid-RUN discards the operation, then MTHI in IDLE
        start_ex = 1'b1;
        op_ex    = OpDivu;
        opa_ex   = 32'd77;
        opb_ex   = 32'd5;
        tick();
        start_ex = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("rstrun.busy", {31'd0, busy}, 32'd0);
        chk("rstrun.done", {31'd0, done}, 32'd0);
        chk("rstrun.lo", lo, 32'h0);
        rst_n      = 1'b1;
        mthi_ex    = 1'b1;
        mt_data_ex = 32'h1234_5678;
        tick();
        mthi_ex = 1'b0;
        chk("rstrun.mthi", hi, 32'h1234_5678);
        chk("rstrun.lo_after", lo, 32'h0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) cyc++;
            tick();
        end
        chk("rstrun.no_done", cyc, 32'd0);
        chk("rstrun.hi_kept", hi, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
